max_int16_reduce_ctrl: RTL and testbench
========================================

# max_int16_reduce_ctrl

Sequencer that reduces a frame of signed WIDTH-bit operands to its maximum. It accepts operands on a valid/ready stream and decides each candidate-vs-running-max comparison with a single shared 1-bit subtract/borrow cell, stepping LSB-first over WIDTH cycles. This is the bit-serial, PIM-style schedule of the signed max datapath. It sits between an operand streamer and a result sink in the benchmark harness.

## Interface
- `WIDTH`, default 16: operand width, two's complement, must be ≥ 2.
- `CNT_W`, default 8: width of the element counter and index outputs.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: operand valid.
- `in_ready`, output, 1: block can accept an operand.
- `in_data`, input, WIDTH: signed operand.
- `in_last`, input, 1: the operand is the final element of the frame.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: sink accepts the result.
- `out_data`, output, WIDTH: frame maximum.
- `out_count`, output, CNT_W: number of elements in the frame, modulo 2^CNT_W.
- `out_index`, output, CNT_W: zero-based index of the maximum. Present only with `MAX_REDUCE_ARGMAX_EN`.

## Operation
- FSM states: IDLE, WAIT, CMP, DONE.
- A transfer occurs on any edge where `in_valid & in_ready`. `in_ready` = 1 only in IDLE and WAIT.
- IDLE, on transfer:
  - max_reg ← in_data, count ← 1, idx ← 0.
  - If `in_last`, go to DONE. Otherwise go to WAIT.
- WAIT, on transfer:
  - cand_reg ← in_data, last_reg ← in_last, count ← count+1, borrow ← 0, bit_cnt ← 0.
  - Go to CMP.
- CMP lasts exactly WIDTH cycles. On cycle i (LSB first):
  - a = cand_reg[0], b = max_reg[0]. On i = WIDTH-1 both bits are inverted (offset-binary conversion).
  - borrow ← (~b & a) | (~(b ^ a) & borrow).
  - cand_reg and max_reg rotate right by one, so both are restored after WIDTH cycles.
- At the end of CMP, if borrow = 1 (cand > max, signed):
  - max_reg ← restored cand_reg.
  - idx ← count-1.
- Leaving CMP: go to DONE if last_reg, else WAIT.
- DONE: `out_valid` = 1. `out_data`, `out_count` and `out_index` are held stable until `out_ready`. On handshake, go to IDLE.
- Ties: the earliest element wins, because replacement requires strictly greater.
- Counter overflow: count and idx wrap modulo 2^CNT_W. No error flag.
- Extremes: -2^(WIDTH-1) and 2^(WIDTH-1)-1 must compare correctly. The MSB inversion guarantees this.
- An `in_valid` while in CMP/DONE is simply not accepted (`in_ready` = 0). The source must hold data stable.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State = IDLE.
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `out_data`, `out_count` and `out_index` = 0.
  - Internal registers = 0.
- Reset mid-frame discards the partial frame. No output is produced for it.
- Frame of N elements, first transfer on edge 0, back-to-back input, `out_ready` = 1:
  - Element k ≥ 2 is accepted on edge 1+(k-2)(WIDTH+1).
  - `out_valid` rises in cycle (N-1)(WIDTH+1)+1.
  - With WIDTH = 16: N = 1 gives cycle 1, N = 2 gives cycle 18.
- Output handshake takes one cycle. The earliest next-frame transfer is the cycle after the DONE handshake (IDLE). There is no bypass.
- Throughput: one element per WIDTH+1 cycles during a frame.

## Configuration
- `MAX_REDUCE_ARGMAX_EN` defined:
  - The `out_index` port and the idx register exist.
  - `out_index` is valid with `out_valid` and held through DONE.
- `MAX_REDUCE_ARGMAX_EN` undefined:
  - The port and register are removed.
  - All other behaviour and timing are identical.

## Test plan
- Single-element frame (in_data = 0x8000, in_last = 1) → `out_valid` in cycle 1, `out_data` = 0x8000, `out_count` = 1, `out_index` = 0.
- Frame {5, -3, 32767, -32768, 32767} → `out_data` = 0x7FFF, `out_count` = 5, `out_index` = 2 (tie keeps the earliest). `out_valid` in cycle 4·17+1 = 69.
- Frame {-1, -2, -32768} → `out_data` = 0xFFFF, `out_index` = 0. Frame {0, -1} → 0x0000, covering sign-boundary comparisons.
- Backpressure:
  - Hold `out_ready` = 0 for 10 cycles in DONE → outputs stable and `in_ready` = 0 throughout.
  - Release → IDLE next cycle and a new frame is accepted.
- Assert `rst_n` = 0 during the CMP of element 3 of a 4-element frame → immediately `out_valid` = 0 and `in_ready` = 1. Send a new frame {7} → `out_data` = 7, `out_count` = 1.
- Send 257 elements (0..256) with CNT_W = 8 → `out_data` = 256, `out_count` = 1 (wrap), `out_index` = 0 (256 mod 256). Randomly gap `in_valid` with no change in the result.

Source files
------------

// File: rtl/max_int16_reduce_ctrl.sv
// max_int16_reduce_ctrl
// Reduces a frame of signed WIDTH-bit operands to its maximum. Each
// candidate-vs-max decision is made by one shared 1-bit subtract/borrow
// cell that walks both operands LSB-first over WIDTH cycles.
//
// Optional feature macro: MAX_REDUCE_ARGMAX_EN adds the idx register and
// the out_index port (zero-based position of the maximum).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand stream handshake
//   in_data, in_last      signed operand, final-element marker
//   out_valid/out_ready   result handshake
//   out_data              frame maximum
//   out_count             element count modulo 2^CNT_W
//   out_index             index of the maximum (MAX_REDUCE_ARGMAX_EN only)
module max_int16_reduce_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count
`ifdef MAX_REDUCE_ARGMAX_EN
    ,
    output logic [CNT_W-1:0] out_index
`endif
);

    localparam int unsigned BIT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, WAIT, CMP, DONE} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   max_reg, max_next;
    logic [WIDTH-1:0]   cand_reg, cand_next;
    logic               last_reg, last_next;
    logic [CNT_W-1:0]   count, count_next;
    logic               borrow, borrow_next;
    logic [BIT_W-1:0]   bit_cnt, bit_next;
`ifdef MAX_REDUCE_ARGMAX_EN
    logic [CNT_W-1:0]   idx, idx_next;
`endif

    logic               xfer;
    logic               msb_step;
    logic               a_bit, b_bit, borrow_step;
    logic [WIDTH-1:0]   cand_rot, max_rot;

    // Serial compare cell: borrow out of (max - cand); MSB step is
    // inverted so two's complement compares as offset binary.
    always_comb begin
        xfer        = in_valid & in_ready;
        msb_step    = (bit_cnt == BIT_W'(WIDTH - 1));
        a_bit       = cand_reg[0] ^ msb_step;
        b_bit       = max_reg[0] ^ msb_step;
        borrow_step = (~b_bit & a_bit) | (~(b_bit ^ a_bit) & borrow);
        cand_rot    = {cand_reg[0], cand_reg[WIDTH-1:1]};
        max_rot     = {max_reg[0], max_reg[WIDTH-1:1]};
    end

    // Next-state and datapath next values
    always_comb begin
        state_next  = state;
        max_next    = max_reg;
        cand_next   = cand_reg;
        last_next   = last_reg;
        count_next  = count;
        borrow_next = borrow;
        bit_next    = bit_cnt;
`ifdef MAX_REDUCE_ARGMAX_EN
        idx_next    = idx;
`endif
        case (state)
            IDLE: begin
                if (xfer) begin
                    max_next   = in_data;
                    count_next = CNT_W'(1);
`ifdef MAX_REDUCE_ARGMAX_EN
                    idx_next   = '0;
`endif
                    state_next = in_last ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (xfer) begin
                    cand_next   = in_data;
                    last_next   = in_last;
                    count_next  = count + CNT_W'(1);
                    borrow_next = 1'b0;
                    bit_next    = '0;
                    state_next  = CMP;
                end
            end
            CMP: begin
                cand_next   = cand_rot;
                max_next    = max_rot;
                borrow_next = borrow_step;
                bit_next    = bit_cnt + BIT_W'(1);
                if (msb_step) begin
                    // Strictly greater replaces, so ties keep the earliest
                    if (borrow_step) begin
                        max_next = cand_rot;
`ifdef MAX_REDUCE_ARGMAX_EN
                        idx_next = count - CNT_W'(1);
`endif
                    end
                    state_next = last_reg ? DONE : WAIT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_reg   <= '0;
            cand_reg  <= '0;
            last_reg  <= 1'b0;
            count     <= '0;
            borrow    <= 1'b0;
            bit_cnt   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
`ifdef MAX_REDUCE_ARGMAX_EN
            idx       <= '0;
`endif
        end else begin
            max_reg   <= max_next;
            cand_reg  <= cand_next;
            last_reg  <= last_next;
            count     <= count_next;
            borrow    <= borrow_next;
            bit_cnt   <= bit_next;
            in_ready  <= (state_next == IDLE) || (state_next == WAIT);
            out_valid <= (state_next == DONE);
`ifdef MAX_REDUCE_ARGMAX_EN
            idx       <= idx_next;
`endif
        end
    end

    // max_reg is restored and frozen in DONE, so it doubles as out_data
    assign out_data  = max_reg;
    assign out_count = count;
`ifdef MAX_REDUCE_ARGMAX_EN
    assign out_index = idx;
`endif

endmodule

// File: tb/tb_max_int16_reduce_ctrl.sv
// Self-checking bench for max_int16_reduce_ctrl: directed frames, a
// behavioural max model feeding a scoreboard queue, latency, backpressure,
// mid-frame reset and counter wrap.
module tb_max_int16_reduce_ctrl;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
`ifdef MAX_REDUCE_ARGMAX_EN
    logic [CNT_W-1:0] out_index;
`endif

    max_int16_reduce_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
`ifdef MAX_REDUCE_ARGMAX_EN
        ,
        .out_index (out_index)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [CNT_W-1:0] count;
        logic [CNT_W-1:0] index;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    logic [WIDTH-1:0] m_max;
    logic [CNT_W-1:0] m_cnt;
    logic [CNT_W-1:0] m_idx;
    bit               in_frame = 1'b0;
    int               e0 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one operand until accepted; update the model, push at frame end.
    task automatic send(input logic [WIDTH-1:0] d, input logic l);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!in_frame) begin
            m_max    = d;
            m_cnt    = CNT_W'(1);
            m_idx    = '0;
            in_frame = 1'b1;
            e0       = cyc;
        end else begin
            m_cnt = m_cnt + CNT_W'(1);
            if ($signed(d) > $signed(m_max)) begin
                m_max = d;
                m_idx = m_cnt - CNT_W'(1);
            end
        end
        if (l) begin
            sb.push_back('{m_max, m_cnt, m_idx});
            in_frame = 1'b0;
        end
    endtask

    // Wait for a result, compare against the scoreboard head, consume it.
    task automatic get_out(input string tag, input int lat_exp);
        int   t = 0;
        exp_t e;
        while (!out_valid && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        if (!out_valid) begin
            chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
        end else begin
            if (lat_exp >= 0) chk({tag, "_latency"}, 32'(cyc - e0), 32'(lat_exp));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({tag, "_data"}, 32'(out_data), 32'(e.data));
                chk({tag, "_count"}, 32'(out_count), 32'(e.count));
`ifdef MAX_REDUCE_ARGMAX_EN
                chk({tag, "_index"}, 32'(out_index), 32'(e.index));
`endif
            end
            if (out_ready) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
`ifdef MAX_REDUCE_ARGMAX_EN
        chk("rst_out_index", 32'(out_index), 32'd0);
`endif
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Single most-negative element
        send(16'h8000, 1'b1);
        get_out("single", 0);
        chk("after_hs_valid", 32'(out_valid), 32'd0);

        // Extremes with a tie on the maximum
        send(16'd5, 1'b0);
        send(16'hFFFD, 1'b0);
        send(16'h7FFF, 1'b0);
        send(16'h8000, 1'b0);
        send(16'h7FFF, 1'b1);
        get_out("five", 4 * (WIDTH + 1));

        // Sign boundary comparisons
        send(16'hFFFF, 1'b0);
        send(16'hFFFE, 1'b0);
        send(16'h8000, 1'b1);
        get_out("neg", 2 * (WIDTH + 1));
        send(16'h0000, 1'b0);
        send(16'hFFFF, 1'b1);
        get_out("zero", WIDTH + 1);
        send(16'hFFFF, 1'b0);
        send(16'h0001, 1'b1);
        get_out("cross", WIDTH + 1);

        // Output backpressure
        out_ready = 1'b0;
        send(16'd3, 1'b0);
        send(16'd9, 1'b1);
        get_out("bp", WIDTH + 1);
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data", 32'(out_data), 32'd9);
            chk("bp_hold_count", 32'(out_count), 32'd2);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);

        // Reset during the compare of element 3 of a 4-element frame
        send(16'd10, 1'b0);
        send(16'd20, 1'b0);
        send(16'd30, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        in_frame = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send(16'd7, 1'b1);
        get_out("post_rst", 0);

        // Count/index wrap over 257 elements with random input gaps
        for (int i = 0; i <= 256; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send(16'(i), (i == 256));
        end
        get_out("wrap", -1);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
